// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, frame bit
// indices and the PRESCALE width.
package uart_pkg;

  localparam int PRESCALE_W = 6;
  localparam int BIT_W      = 4;

  localparam logic [BIT_W-1:0] BIT_START     = 4'd0;
  localparam logic [BIT_W-1:0] BIT_LAST_DATA = 4'd8;
  localparam logic [BIT_W-1:0] BIT_PAR       = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversampling position tracker: edge_cnt runs 0..prescale-1 inside a bit and
// bit_cnt advances on each wrap. Both clear while enable is low.
module edge_bit_counter
  import uart_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]      bit_cnt
);

  logic [PRESCALE_W-1:0] last_edge;

  assign last_edge = prescale - {{(PRESCALE_W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= BIT_START;
    end else if (!enable) begin
      edge_cnt <= '0;
      bit_cnt  <= BIT_START;
    end else if (edge_cnt == last_edge) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizes RX_IN, majority-votes three mid-bit
// samples, strobes the external deserializer and checks parity/stop bits.
module uart_rx_ctrl
  import uart_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [7:0]            P_DATA,
  output logic                  sampled_bit,
  output logic                  deser_en,
  output logic [BIT_W-1:0]      bit_cnt,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  logic                  rx_meta;
  logic                  rx_s;
  state_t                state;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic                  count_en;
  logic                  s_early;
  logic                  s_mid;
  logic                  s_late;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] mid_lo;
  logic [PRESCALE_W-1:0] mid_hi;
  logic [PRESCALE_W-1:0] decide_edge;
  logic [PRESCALE_W-1:0] last_edge;
  logic                  at_decide;
  logic                  at_wrap;
  logic                  maj;
  logic                  exp_par;

  // Two-flop synchronizer; idles high so reset does not fake a start edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
    end
  end

  assign count_en = (state != IDLE);

  edge_bit_counter u_counter (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (count_en),
    .prescale (prescale_q),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt)
  );

  assign half        = {1'b0, prescale_q[PRESCALE_W-1:1]};
  assign mid_lo      = half - 6'd1;
  assign mid_hi      = half + 6'd1;
  assign decide_edge = half + 6'd2;
  assign last_edge   = prescale_q - 6'd1;
  assign at_decide   = (edge_cnt == decide_edge);
  assign at_wrap     = (edge_cnt == last_edge);
  assign maj         = majority3(s_early, s_mid, s_late);
  assign exp_par     = (^P_DATA) ^ par_typ_q;

  // The three samples are complete one cycle after the last capture, so every
  // decision (glitch, data strobe, parity, stop) happens at decide_edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      prescale_q  <= 6'd8;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      s_early     <= 1'b1;
      s_mid       <= 1'b1;
      s_late      <= 1'b1;
      sampled_bit <= 1'b0;
      deser_en    <= 1'b0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      deser_en   <= 1'b0;
      data_valid <= 1'b0;

      if (state != IDLE) begin
        if (edge_cnt == mid_lo) s_early <= rx_s;
        if (edge_cnt == half)   s_mid   <= rx_s;
        if (edge_cnt == mid_hi) s_late  <= rx_s;
        if (at_decide)          sampled_bit <= maj;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state      <= START;
            prescale_q <= PRESCALE;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
          end
        end
        START: begin
          if (at_decide && maj) begin
            state <= IDLE;
          end else if (at_wrap) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (at_decide) deser_en <= 1'b1;
          if (at_wrap && bit_cnt == BIT_LAST_DATA) begin
            state <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (at_decide && bit_cnt == BIT_PAR && maj != exp_par) par_err <= 1'b1;
          if (at_wrap) state <= STOP;
        end
        STOP: begin
          // Leaving early frees IDLE to catch a start bit right after this one.
          if (at_decide) begin
            stp_err    <= ~maj;
            data_valid <= maj & ~par_err;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed scoreboard bench for uart_rx_ctrl with a behavioural deserializer
// feeding P_DATA back from the deser_en strobes.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] PRESCALE = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       sampled_bit;
  logic       deser_en;
  logic [3:0] bit_cnt;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int total = 0;
  int bad = 0;
  int deser_seen = 0;
  int valid_seen = 0;

  typedef struct packed {
    logic [3:0] idx;
    logic       b;
  } deser_t;

  deser_t     deser_q[$];
  logic [7:0] frame_q[$];
  deser_t     mon_e;
  logic [7:0] mon_byte;

  uart_rx_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PRESCALE    (PRESCALE),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .P_DATA      (P_DATA),
    .sampled_bit (sampled_bit),
    .deser_en    (deser_en),
    .bit_cnt     (bit_cnt),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err)
  );

  always #5 CLK = ~CLK;

  // Downstream deserializer model: writes sampled_bit at position bit_cnt-1.
  always @(posedge CLK or negedge RST) begin
    if (!RST) P_DATA <= 8'h00;
    else if (deser_en && bit_cnt >= 4'd1 && bit_cnt <= 4'd8)
      P_DATA[bit_cnt - 4'd1] <= sampled_bit;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes.
  always @(negedge CLK) begin
    if (RST) begin
      if (deser_en) begin
        deser_seen++;
        if (deser_q.size() == 0) begin
          check_output("unexpected deser_en", {31'd0, deser_en}, 32'd0);
        end else begin
          mon_e = deser_q.pop_front();
          check_output("deser bit_cnt", {28'd0, bit_cnt}, {28'd0, mon_e.idx});
          check_output("deser sampled_bit", {31'd0, sampled_bit}, {31'd0, mon_e.b});
        end
      end
      if (data_valid) begin
        valid_seen++;
        if (frame_q.size() == 0) begin
          check_output("unexpected data_valid", {31'd0, data_valid}, 32'd0);
        end else begin
          mon_byte = frame_q.pop_front();
          check_output("frame byte", {24'd0, P_DATA}, {24'd0, mon_byte});
        end
      end
    end
  end

  task automatic drive_bit(input logic v, input int p);
    RX_IN = v;
    repeat (p) @(negedge CLK);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input int p, input logic pe, input logic pt,
                                input logic pbit, input logic stopb, input logic exp_par, input logic exp_stp);
    deser_t e;
    PRESCALE = p[5:0];
    PAR_EN   = pe;
    PAR_TYP  = pt;
    for (int i = 0; i < 8; i++) begin
      e.idx = 4'(i + 1);
      e.b   = d[i];
      deser_q.push_back(e);
    end
    if (!exp_par && !exp_stp) frame_q.push_back(d);
    drive_bit(1'b0, p);
    check_output("par_err cleared at start", {31'd0, par_err}, 32'd0);
    check_output("stp_err cleared at start", {31'd0, stp_err}, 32'd0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pe) drive_bit(pbit, p);
    drive_bit(stopb, p);
    RX_IN = 1'b1;
  endtask

  task automatic check_flags(input logic exp_par, input logic exp_stp);
    check_output("par_err", {31'd0, par_err}, {31'd0, exp_par});
    check_output("stp_err", {31'd0, stp_err}, {31'd0, exp_stp});
  endtask

  int d0;
  int v0;

  initial begin
    repeat (3) @(negedge CLK);
    #1;
    check_output("reset outputs", {22'd0, sampled_bit, deser_en, bit_cnt, data_valid, par_err, stp_err}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    idle(10);

    // 0xA5, P=8, no parity
    d0 = deser_seen; v0 = valid_seen;
    apply_stimulus(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(24);
    check_flags(1'b0, 1'b0);
    check_output("A5 deser count", deser_seen - d0, 8);
    check_output("A5 valid count", valid_seen - v0, 1);

    // 0x03, P=16, even parity: wrong parity bit, then correct one
    d0 = deser_seen; v0 = valid_seen;
    apply_stimulus(8'h03, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(48);
    check_flags(1'b1, 1'b0);
    check_output("parity bad valid count", valid_seen - v0, 0);
    apply_stimulus(8'h03, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(48);
    check_flags(1'b0, 1'b0);
    check_output("parity good valid count", valid_seen - v0, 1);

    // 0x03, P=8, odd parity expects parity bit 1
    v0 = valid_seen;
    apply_stimulus(8'h03, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(24);
    check_flags(1'b0, 1'b0);
    check_output("odd parity valid count", valid_seen - v0, 1);

    // stop bit low, then a clean frame clears the flag on its start edge
    v0 = valid_seen;
    apply_stimulus(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(24);
    check_flags(1'b0, 1'b1);
    check_output("stop error valid count", valid_seen - v0, 0);
    apply_stimulus(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(24);
    check_flags(1'b0, 1'b0);

    // two-cycle glitch while idle
    d0 = deser_seen; v0 = valid_seen;
    PRESCALE = 6'd8;
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    idle(40);
    check_output("glitch deser count", deser_seen - d0, 0);
    check_output("glitch valid count", valid_seen - v0, 0);
    check_output("glitch bit_cnt idle", {28'd0, bit_cnt}, 32'd0);

    // P=32, reset in the middle of data bit 4, then a clean 0x3C
    v0 = valid_seen;
    PRESCALE = 6'd32;
    PAR_EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mon_e.idx = 4'(i + 1);
      mon_e.b   = 1'(8'hC5 >> i);
      deser_q.push_back(mon_e);
    end
    drive_bit(1'b0, 32);
    drive_bit(1'b1, 32);
    drive_bit(1'b0, 32);
    drive_bit(1'b1, 32);
    drive_bit(1'b0, 8);
    check_output("bit_cnt before reset", {28'd0, bit_cnt}, 32'd4);
    RST = 1'b0;
    #1;
    check_output("outputs under reset", {22'd0, sampled_bit, deser_en, bit_cnt, data_valid, par_err, stp_err}, 32'd0);
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    idle(40);
    check_output("aborted frame valid count", valid_seen - v0, 0);
    check_output("aborted frame pending", deser_q.size(), 0);
    apply_stimulus(8'h3C, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(96);
    check_output("post-reset valid count", valid_seen - v0, 1);

    // back-to-back frames, single stop bit, P=8
    d0 = deser_seen; v0 = valid_seen;
    apply_stimulus(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(8'hEF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(24);
    check_output("b2b deser count", deser_seen - d0, 16);
    check_output("b2b valid count", valid_seen - v0, 2);

    check_output("deser queue drained", deser_q.size(), 0);
    check_output("frame queue drained", frame_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have ports: CLK in 1 (receive oversampling clock); RST in 1 (asynchronous, active-low reset).
REQ-002 SHALL have: RX_IN in 1, serial line, idle high.
REQ-003 SHALL have: PRESCALE in 6, oversampling ratio; even values 8..32 supported.
REQ-004 SHALL have: PAR_EN in 1, parity bit present; PAR_TYP in 1, 0 even / 1 odd.
REQ-005 SHALL have: P_DATA in 8, assembled byte returned from the downstream deserializer.
REQ-006 SHALL have: sampled_bit out 1, majority-voted bit value; deser_en out 1, one-cycle write strobe; bit_cnt out 4, frame bit index.
REQ-007 SHALL have: data_valid out 1, one-cycle good-frame pulse; par_err out 1, parity error flag; stp_err out 1, stop-bit error flag.

Function
REQ-008 RX_IN SHALL pass through a two-flop synchronizer; all behaviour references the synchronized value rx_s.
REQ-009 PRESCALE, PAR_EN and PAR_TYP SHALL be latched on the IDLE->START transition and held constant for the frame.
REQ-010 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-011 edge_cnt SHALL count 0..P-1 within each bit, where P is the latched PRESCALE; it wraps to 0 at P-1, and bit_cnt increments on that wrap.
REQ-012 bit_cnt SHALL hold 0 for start, 1..8 for data LSB-first, 9 for parity when enabled, and 9 or 10 for stop.
REQ-013 rx_s SHALL be captured at edge_cnt = P/2-1, P/2 and P/2+1; sampled_bit SHALL be registered to the 2-of-3 majority at edge_cnt = P/2+2 and held until the next update.
REQ-014 IDLE: rx_s=0 SHALL move the FSM to START with edge_cnt=0, bit_cnt=0, par_err=0 and stp_err=0.
REQ-015 START: a majority of 1 SHALL be treated as a glitch, returning the FSM to IDLE with no strobes; at the bit end the FSM SHALL move to DATA.
REQ-016 DATA: deser_en SHALL pulse exactly one cycle at edge_cnt = P/2+2, concurrent with the sampled_bit update and with bit_cnt equal to the current data index.
REQ-017 After the bit-8 wrap, the FSM SHALL move to PARITY if PAR_EN=1, otherwise to STOP.
REQ-018 PARITY: expected parity SHALL be XOR(P_DATA) for even, or its inverse for odd; a mismatch SHALL set par_err at edge_cnt = P/2+2.
REQ-019 STOP: at edge_cnt = P/2+2, a majority of 0 SHALL set stp_err; the FSM SHALL then move to IDLE in the same cycle, allowing back-to-back frames.
REQ-020 data_valid SHALL pulse one cycle at the STOP decision point only if par_err=0 and the stop bit is 1.
REQ-021 par_err and stp_err SHALL hold until the next IDLE->START transition.
REQ-022 No deser_en or data_valid pulse SHALL occur outside the cases above.
REQ-023 A falling edge during STOP after the decision point SHALL be handled by IDLE on the next cycle.

Reset
REQ-024 On RST low, all outputs SHALL be 0, state SHALL be IDLE, edge_cnt=0, bit_cnt=0, and the synchronizer flops SHALL be 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no data_valid pulse; reception resumes on the first falling edge after release.

Structure
REQ-026 State encoding, the bit index constants (START=0, PAR=9) and the PRESCALE width SHALL reside in the shared package uart_pkg.
REQ-027 edge_cnt/bit_cnt SHALL be implemented in sub-module edge_bit_counter (inputs: enable, prescale; outputs: edge_cnt, bit_cnt).

Verification
REQ-028 P=8, no parity, frame 0xA5 -> deser_en pulses 8 times with bit_cnt 1..8, sampled_bit = 1,0,1,0,0,1,0,1, one data_valid, no errors.
REQ-029 P=16, PAR_EN=1, PAR_TYP=0, byte 0x03, parity bit 1 -> par_err=1 and no data_valid; repeat with parity bit 0 -> data_valid.
REQ-030 P=8, stop bit driven 0 -> stp_err=1, no data_valid; error flags clear on the next start edge.
REQ-031 P=8, 2-cycle low glitch while idle -> return to IDLE, zero deser_en pulses.
REQ-032 P=32, RST pulsed low at bit_cnt=4 -> all outputs 0 immediately; the following clean frame 0x3C -> data_valid.
REQ-033 P=8, two back-to-back frames with a single stop bit -> two data_valid pulses, 16 deser_en pulses.
